// File: rtl/word_ascii_streamer_pkg.sv
// Shared state encoding and ASCII constants for word_ascii_streamer.
// Macro WORD_ASCII_CRLF_EN adds the carriage-return state ahead of the line feed.
package word_ascii_streamer_pkg;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SEND     = 3'd1;
  localparam logic [2:0] S_WAIT     = 3'd2;
  localparam logic [2:0] S_EOL_CR   = 3'd3;
  localparam logic [2:0] S_EOL_LF   = 3'd4;
  localparam logic [2:0] S_EOL_WAIT = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE     = S_IDLE,
    ST_SEND     = S_SEND,
    ST_WAIT     = S_WAIT,
`ifdef WORD_ASCII_CRLF_EN
    ST_EOL_CR   = S_EOL_CR,
`endif
    ST_EOL_LF   = S_EOL_LF,
    ST_EOL_WAIT = S_EOL_WAIT
  } state_t;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam int RADIX_BIN = 1;
  localparam int RADIX_HEX = 4;

endpackage

// File: rtl/word_ascii_streamer_digit_to_ascii.sv
// Combinational digit-to-character map: binary looks only at bit 0,
// hex yields uppercase "0"-"9","A"-"F".
module digit_to_ascii
  import word_ascii_streamer_pkg::*;
#(
  parameter int RADIX_BITS = 1
) (
  input  logic [3:0] i_value,
  output logic [7:0] o_ascii
);

  always_comb begin
    o_ascii = ASCII_0;
    if (RADIX_BITS == RADIX_BIN) begin
      o_ascii = ASCII_0 + {7'd0, i_value[0]};
    end else if (i_value < 4'd10) begin
      o_ascii = ASCII_0 + {4'd0, i_value};
    end else begin
      o_ascii = ASCII_A + {4'd0, i_value} - 8'd10;
    end
  end

endmodule

// File: rtl/word_ascii_streamer.sv
// Streams one accepted word as MSB-first ASCII digits plus a line terminator.
// Define WORD_ASCII_CRLF_EN for a CR+LF terminator; otherwise LF only.
module word_ascii_streamer
  import word_ascii_streamer_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_word_valid,
  output logic             o_word_ready,
  input  logic [WIDTH-1:0] i_word,
  output logic             o_tx_dv,
  output logic [7:0]       o_tx_byte,
  input  logic             i_tx_done
);

  localparam int DIGITS = WIDTH / RADIX_BITS;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  if (((WIDTH % RADIX_BITS) != 0) ||
      ((RADIX_BITS != RADIX_BIN) && (RADIX_BITS != RADIX_HEX))) begin : g_bad_cfg
    $error("word_ascii_streamer: WIDTH must be a multiple of RADIX_BITS, RADIX_BITS must be 1 or 4");
  end

  state_t           r_state, w_state_next;
  logic [IDX_W-1:0] r_index, w_index_next;
  logic [WIDTH-1:0] r_shadow, w_shadow_next;
  logic             r_cr_sent, w_cr_sent_next;
  logic             r_word_ready;
  logic             r_tx_dv, w_dv_next;
  logic [7:0]       r_tx_byte, w_byte_next;

  logic [RADIX_BITS-1:0] w_digit_bits;
  logic [3:0]            w_digit;
  logic [7:0]            w_digit_ascii;

  always_comb begin
    w_state_next   = r_state;
    w_index_next   = r_index;
    w_shadow_next  = r_shadow;
    w_cr_sent_next = r_cr_sent;
    case (r_state)
      ST_IDLE: begin
        if (i_word_valid && r_word_ready) begin
          w_shadow_next = i_word;
          w_index_next  = LAST_IDX;
          w_state_next  = ST_SEND;
        end
      end
      ST_SEND: w_state_next = ST_WAIT;
      ST_WAIT: begin
        if (i_tx_done) begin
          if (r_index != '0) begin
            w_index_next = r_index - IDX_W'(1);
            w_state_next = ST_SEND;
          end else begin
`ifdef WORD_ASCII_CRLF_EN
            w_state_next = ST_EOL_CR;
`else
            w_state_next = ST_EOL_LF;
`endif
          end
        end
      end
`ifdef WORD_ASCII_CRLF_EN
      ST_EOL_CR: begin
        w_cr_sent_next = 1'b1;
        w_state_next   = ST_EOL_WAIT;
      end
`endif
      ST_EOL_LF: begin
        w_cr_sent_next = 1'b0;
        w_state_next   = ST_EOL_WAIT;
      end
      ST_EOL_WAIT: begin
        if (i_tx_done) begin
          w_state_next = r_cr_sent ? ST_EOL_LF : ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered strobe lines up with SEND/EOL cycles.
  always_comb begin
    w_digit_bits = w_shadow_next[int'(w_index_next) * RADIX_BITS +: RADIX_BITS];
    w_digit      = 4'(w_digit_bits);
  end

  digit_to_ascii #(
    .RADIX_BITS(RADIX_BITS)
  ) u_digit (
    .i_value(w_digit),
    .o_ascii(w_digit_ascii)
  );

  always_comb begin
    w_dv_next   = 1'b0;
    w_byte_next = r_tx_byte;
    case (w_state_next)
      ST_SEND: begin
        w_dv_next   = 1'b1;
        w_byte_next = w_digit_ascii;
      end
`ifdef WORD_ASCII_CRLF_EN
      ST_EOL_CR: begin
        w_dv_next   = 1'b1;
        w_byte_next = ASCII_CR;
      end
`endif
      ST_EOL_LF: begin
        w_dv_next   = 1'b1;
        w_byte_next = ASCII_LF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_index      <= '0;
      r_shadow     <= '0;
      r_cr_sent    <= 1'b0;
      r_word_ready <= 1'b0;
      r_tx_dv      <= 1'b0;
      r_tx_byte    <= 8'h00;
    end else begin
      r_state      <= w_state_next;
      r_index      <= w_index_next;
      r_shadow     <= w_shadow_next;
      r_cr_sent    <= w_cr_sent_next;
      r_word_ready <= (w_state_next == ST_IDLE);
      r_tx_dv      <= w_dv_next;
      r_tx_byte    <= w_byte_next;
    end
  end

  assign o_word_ready = r_word_ready;
  assign o_tx_dv      = r_tx_dv;
  assign o_tx_byte    = r_tx_byte;

endmodule

// File: tb/tb_word_ascii_streamer.sv
// Directed bench for word_ascii_streamer: a 4-bit binary instance and a 32-bit hex instance,
// each driven by a small transmitter model that answers TX_DV with a delayed TX_DONE.
module tb_word_ascii_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    errors = 0;
  int    checks = 0;
  string eol;
  int    bLineLen;
  int    hLineLen;

  logic       bValid = 1'b0, bReady, bDv, bDone = 1'b0;
  logic [3:0] bWord  = 4'd0;
  logic [7:0] bByte;

  logic        hValid = 1'b0, hReady, hDv, hDone = 1'b0, hSpur = 1'b0;
  logic [31:0] hWord  = 32'd0;
  logic [7:0]  hByte;

  word_ascii_streamer #(.WIDTH(4), .RADIX_BITS(1)) dutBin (
    .i_clk(clk), .i_rst(rst), .i_word_valid(bValid), .o_word_ready(bReady),
    .i_word(bWord), .o_tx_dv(bDv), .o_tx_byte(bByte), .i_tx_done(bDone)
  );

  word_ascii_streamer #(.WIDTH(32), .RADIX_BITS(4)) dutHex (
    .i_clk(clk), .i_rst(rst), .i_word_valid(hValid), .o_word_ready(hReady),
    .i_word(hWord), .o_tx_dv(hDv), .o_tx_byte(hByte), .i_tx_done(hDone | hSpur)
  );

  // Transmitter models: capture each strobed character, watch it stay put, then pulse done.
  logic [7:0] bBytes[$];
  int bDoneCyc[$];
  int bDelay = 10, bCnt = 0, bUnstable = 0, bDvWhileBusy = 0;
  bit bBusy = 1'b0;
  logic [7:0] bHeld = 8'h00;

  always begin
    @(posedge clk); #1;
    bDone = 1'b0;
    if (rst) begin
      bBusy = 1'b0;
    end else if (bBusy) begin
      if (bByte !== bHeld) bUnstable++;
      if (bDv !== 1'b0) bDvWhileBusy++;
      bCnt--;
      if (bCnt <= 0) begin
        bDone = 1'b1;
        bBusy = 1'b0;
        bDoneCyc.push_back(cyc);
      end
    end else if (bDv === 1'b1) begin
      bBytes.push_back(bByte);
      bHeld = bByte;
      bBusy = 1'b1;
      bCnt  = bDelay;
    end
  end

  logic [7:0] hBytes[$];
  int hDvCyc[$];
  int hDoneCyc[$];
  int hDelay = 3, hCnt = 0, hUnstable = 0, hDvWhileBusy = 0;
  bit hBusy = 1'b0, hRand = 1'b0;
  logic [7:0] hHeld = 8'h00;

  always begin
    @(posedge clk); #1;
    hDone = 1'b0;
    if (rst) begin
      hBusy = 1'b0;
    end else if (hBusy) begin
      if (hByte !== hHeld) hUnstable++;
      if (hDv !== 1'b0) hDvWhileBusy++;
      hCnt--;
      if (hCnt <= 0) begin
        hDone = 1'b1;
        hBusy = 1'b0;
        hDoneCyc.push_back(cyc);
      end
    end else if (hDv === 1'b1) begin
      hBytes.push_back(hByte);
      hDvCyc.push_back(cyc);
      hHeld = hByte;
      hBusy = 1'b1;
      hCnt  = hRand ? int'($urandom_range(200, 1)) : hDelay;
    end
  end

  function automatic string bytesToHex(input logic [7:0] q[$]);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  function automatic string textToHex(input string t);
    string s = "";
    for (int i = 0; i < t.len(); i++) s = {s, $sformatf("%02h ", t[i])};
    return s;
  endfunction

  task automatic clearHex();
    hBytes.delete();
    hDvCyc.delete();
    hDoneCyc.delete();
  endtask

  // Present a word, wait (bounded) for acceptance, then scramble the bus; returns just after the accepting edge.
  task automatic applyStimulusHex(input logic [31:0] w);
    hWord  = w;
    hValid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (hReady === 1'b1) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    hValid = 1'b0;
    hWord  = ~w;
  endtask

  task automatic applyStimulusBin(input logic [3:0] w);
    bWord  = w;
    bValid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (bReady === 1'b1) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bValid = 1'b0;
    bWord  = ~w;
  endtask

  task automatic waitHexReady(output int readyCyc);
    readyCyc = -1;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #1;
      if (hReady === 1'b1) begin
        readyCyc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({hReady, hDv, hByte} !== 10'd0) begin
      errors++;
      $display("[TB] FAIL reset_hex: ready=%0b dv=%0b byte=%02h, want 0 0 00", hReady, hDv, hByte);
    end
    checks++;
    if ({bReady, bDv, bByte} !== 10'd0) begin
      errors++;
      $display("[TB] FAIL reset_bin: ready=%0b dv=%0b byte=%02h, want 0 0 00", bReady, bDv, bByte);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (hReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ready_before_edge: got %0b want 0", hReady);
    end
    @(posedge clk); #1;
    checks++;
    if (hReady !== 1'b1 || bReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_after_release: hex=%0b bin=%0b want 1 1", hReady, bReady);
    end
  endtask

  task automatic test_binary();
    int    readyCyc;
    int    lastDone;
    string act, exp;
    @(negedge clk);
    bBytes.delete();
    bDoneCyc.delete();
    bDelay = 10;
    @(posedge clk); #1;
    applyStimulusBin(4'b1010);
    checks++;
    if (bDv !== 1'b1 || bByte !== 8'h31) begin
      errors++;
      $display("[TB] FAIL bin_first_char: dv=%0b byte=%02h want 1 31", bDv, bByte);
    end
    readyCyc = -1;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (bReady === 1'b1) begin
        readyCyc = cyc;
        break;
      end
    end
    @(negedge clk);
    act = bytesToHex(bBytes);
    exp = textToHex({"1010", eol});
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL bin_bytes: got %s want %s", act, exp);
    end
    checks++;
    if (bBytes.size() != bLineLen || bDvWhileBusy != 0) begin
      errors++;
      $display("[TB] FAIL bin_dv_pulses: got %0d (long strobes %0d) want %0d (0)", bBytes.size(), bDvWhileBusy, bLineLen);
    end
    lastDone = (bDoneCyc.size() == 0) ? -99 : bDoneCyc[$];
    checks++;
    if (readyCyc != lastDone + 1 || bReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bin_ready_after_line: ready=%0b at cycle %0d want 1 at %0d", bReady, readyCyc, lastDone + 1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_hex_word();
    int    readyCyc;
    int    badGap;
    int    lastDone;
    string act, exp;
    @(negedge clk);
    clearHex();
    hDelay = 3;
    @(posedge clk); #1;
    applyStimulusHex(32'hDEADBEEF);
    checks++;
    if (hDv !== 1'b1 || hByte !== 8'h44) begin
      errors++;
      $display("[TB] FAIL hex_first_char: dv=%0b byte=%02h want 1 44", hDv, hByte);
    end
    waitHexReady(readyCyc);
    @(negedge clk);
    act = bytesToHex(hBytes);
    exp = textToHex({"DEADBEEF", eol});
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL hex_bytes: got %s want %s", act, exp);
    end
    badGap = 0;
    for (int i = 0; i + 1 < hDvCyc.size(); i++) begin
      if (i >= hDoneCyc.size() || hDvCyc[i+1] != hDoneCyc[i] + 1) badGap++;
    end
    checks++;
    if (badGap != 0 || hDvCyc.size() != hLineLen) begin
      errors++;
      $display("[TB] FAIL hex_done_to_dv: late strobes %0d of %0d chars, want 0 of %0d", badGap, hDvCyc.size(), hLineLen);
    end
    lastDone = (hDoneCyc.size() == 0) ? -99 : hDoneCyc[$];
    checks++;
    if (readyCyc != lastDone + 1) begin
      errors++;
      $display("[TB] FAIL hex_ready_timing: ready at cycle %0d want %0d", readyCyc, lastDone + 1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int    rc1, rc2;
    int    endDone;
    int    secondDv;
    string act, exp;
    @(negedge clk);
    clearHex();
    hDelay = 2;
    @(posedge clk); #1;
    hWord  = 32'h00000001;
    hValid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (hReady === 1'b1) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    hWord = 32'h80000000;
    waitHexReady(rc1);
    @(posedge clk); #1;
    hValid = 1'b0;
    hWord  = 32'h0;
    waitHexReady(rc2);
    @(negedge clk);
    act = bytesToHex(hBytes);
    exp = textToHex({"00000001", eol, "80000000", eol});
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL b2b_bytes: got %s want %s", act, exp);
    end
    endDone  = (hDoneCyc.size() >= hLineLen) ? hDoneCyc[hLineLen-1] : -99;
    secondDv = (hDvCyc.size() > hLineLen) ? hDvCyc[hLineLen] : -1;
    checks++;
    if (rc1 != endDone + 1 || secondDv != endDone + 2) begin
      errors++;
      $display("[TB] FAIL b2b_timing: ready at %0d, next strobe at %0d; want %0d, %0d", rc1, secondDv, endDone + 1, endDone + 2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_spurious_done();
    int    readyCyc;
    string act, exp;
    @(negedge clk);
    clearHex();
    hDelay = 4;
    @(posedge clk); #1;
    hSpur = 1'b1;
    @(posedge clk); #1;
    hSpur = 1'b0;
    applyStimulusHex(32'h0F1E2D3C);
    hSpur = 1'b1;
    @(posedge clk); #1;
    hSpur = 1'b0;
    waitHexReady(readyCyc);
    @(negedge clk);
    act = bytesToHex(hBytes);
    exp = textToHex({"0F1E2D3C", eol});
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL spurious_done_bytes: got %s want %s", act, exp);
    end
    checks++;
    if (hReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL spurious_done_ready: got %0b want 1", hReady);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midline();
    int    readyCyc;
    string act, exp;
    @(negedge clk);
    clearHex();
    hDelay = 10;
    @(posedge clk); #1;
    applyStimulusHex(32'h00001234);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (hBytes.size() >= 3) break;
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (hDv !== 1'b0 || hByte !== 8'h00 || hReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_midline_outputs: dv=%0b byte=%02h ready=%0b want 0 00 0", hDv, hByte, hReady);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    act = bytesToHex(hBytes);
    exp = textToHex("000");
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL reset_midline_residue: got %s want %s", act, exp);
    end
    clearHex();
    @(posedge clk); #1;
    applyStimulusHex(32'h000000FF);
    waitHexReady(readyCyc);
    @(negedge clk);
    act = bytesToHex(hBytes);
    exp = textToHex({"000000FF", eol});
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL reset_midline_next_line: got %s want %s", act, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_byte_stability();
    int    readyCyc;
    string act, exp;
    @(negedge clk);
    clearHex();
    hRand = 1'b1;
    @(posedge clk); #1;
    applyStimulusHex(32'hA5C30F96);
    waitHexReady(readyCyc);
    @(negedge clk);
    hRand = 1'b0;
    act = bytesToHex(hBytes);
    exp = textToHex({"A5C30F96", eol});
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL stability_bytes: got %s want %s", act, exp);
    end
    checks++;
    if (hUnstable != 0 || bUnstable != 0) begin
      errors++;
      $display("[TB] FAIL byte_stable: changes while busy hex=%0d bin=%0d want 0 0", hUnstable, bUnstable);
    end
    checks++;
    if (hDvWhileBusy != 0) begin
      errors++;
      $display("[TB] FAIL dv_single_cycle: strobes while busy %0d want 0", hDvWhileBusy);
    end
  endtask

  initial begin
`ifdef WORD_ASCII_CRLF_EN
    eol = "\r\n";
`else
    eol = "\n";
`endif
    bLineLen = 4 + eol.len();
    hLineLen = 8 + eol.len();
    $display("[TB] starting, terminator length %0d", eol.len());
    test_reset();
    test_binary();
    test_hex_word();
    test_back_to_back();
    test_spurious_done();
    test_reset_midline();
    test_byte_stability();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
